// File: rtl/history_checkpoint_ctrl.sv
// Speculative global-history owner with an in-order checkpoint queue of in-flight predictions.
// Latency: history updates one cycle after a push; train_* outputs appear one cycle after a resolve.
// Backpressure: predict_ready drops when the queue is full, during a mispredict, and for one recovery cycle.
module history_checkpoint_ctrl #(
  parameter int HIST_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              predict_valid,
  input  logic              predict_taken,
  output logic              predict_ready,
  output logic [PTR_W-1:0]  predict_tag,
  output logic [HIST_W-1:0] predict_history,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              train_valid,
  output logic              train_taken,
  output logic              train_mispredicted,
  output logic [HIST_W-1:0] train_history,
  output logic [PTR_W:0]    occupancy,
  output logic              err_underflow
);

  typedef struct packed {
    logic [HIST_W-1:0] hist;
    logic              taken;
  } ckpt_t;

  typedef enum logic {RUN, RECOVER} state_t;

  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    occ_q, occ_d;
  logic              train_valid_q, train_valid_d;
  logic              train_taken_q, train_taken_d;
  logic              train_mispred_q, train_mispred_d;
  logic [HIST_W-1:0] train_hist_q, train_hist_d;
  logic              err_q, err_d;

  ckpt_t ckpt_q [DEPTH];
  ckpt_t rd_entry;

  logic resolve_acc;
  logic mispredict_now;
  logic push;

  assign rd_entry       = ckpt_q[rd_ptr_q];
  assign resolve_acc    = resolve_valid && (occ_q != '0);
  assign mispredict_now = resolve_acc && (resolve_taken != rd_entry.taken);
  // Ready looks at registered occupancy, so a full queue cannot refill on the cycle it pops.
  assign predict_ready  = (state_q == RUN) && (occ_q != FULL_OCC) && !mispredict_now;
  assign push           = predict_valid && predict_ready;

  always_comb begin
    state_d         = RUN;
    hist_d          = hist_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    occ_d           = occ_q;
    train_valid_d   = resolve_acc;
    train_taken_d   = train_taken_q;
    train_mispred_d = train_mispred_q;
    train_hist_d    = train_hist_q;
    err_d           = err_q || (resolve_valid && (occ_q == '0));

    if (resolve_acc) begin
      train_taken_d   = resolve_taken;
      train_mispred_d = mispredict_now;
      train_hist_d    = rd_entry.hist;
    end

    if (mispredict_now) begin
      // Rebuild history from the faulting branch's checkpoint and drop every younger entry.
      hist_d   = {rd_entry.hist[HIST_W-2:0], resolve_taken};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      state_d  = RECOVER;
    end else begin
      if (push) begin
        hist_d   = {hist_q[HIST_W-2:0], predict_taken};
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (resolve_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      occ_d = occ_q + (PTR_W+1)'(push) - (PTR_W+1)'(resolve_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= RUN;
      hist_q          <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      occ_q           <= '0;
      train_valid_q   <= 1'b0;
      train_taken_q   <= 1'b0;
      train_mispred_q <= 1'b0;
      train_hist_q    <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      hist_q          <= hist_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      occ_q           <= occ_d;
      train_valid_q   <= train_valid_d;
      train_taken_q   <= train_taken_d;
      train_mispred_q <= train_mispred_d;
      train_hist_q    <= train_hist_d;
      err_q           <= err_d;
    end
  end

  // Checkpoint storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      ckpt_q[wr_ptr_q] <= '{hist: hist_q, taken: predict_taken};
    end
  end

  assign predict_tag        = wr_ptr_q;
  assign predict_history    = hist_q;
  assign occupancy          = occ_q;
  assign train_valid        = train_valid_q;
  assign train_taken        = train_taken_q;
  assign train_mispredicted = train_mispred_q;
  assign train_history      = train_hist_q;
  assign err_underflow      = err_q;

endmodule

// File: tb/tb_history_checkpoint_ctrl.sv
// Directed bench for history_checkpoint_ctrl: hand-computed expectations per scenario.
module tb_history_checkpoint_ctrl;

  localparam int HIST_W = 32;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;

  logic              clk;
  logic              resetn;
  logic              predict_valid;
  logic              predict_taken;
  logic              predict_ready;
  logic [PTR_W-1:0]  predict_tag;
  logic [HIST_W-1:0] predict_history;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              train_valid;
  logic              train_taken;
  logic              train_mispredicted;
  logic [HIST_W-1:0] train_history;
  logic [PTR_W:0]    occupancy;
  logic              err_underflow;

  int tests;
  int fails;

  history_checkpoint_ctrl #(.HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .predict_valid      (predict_valid),
    .predict_taken      (predict_taken),
    .predict_ready      (predict_ready),
    .predict_tag        (predict_tag),
    .predict_history    (predict_history),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .train_valid        (train_valid),
    .train_taken        (train_taken),
    .train_mispredicted (train_mispredicted),
    .train_history      (train_history),
    .occupancy          (occupancy),
    .err_underflow      (err_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic t);
    predict_valid = 1'b1;
    predict_taken = t;
    tick();
    predict_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] tk_v;
    tk_v = 3'b101;
    resetn = 1'b0;
    predict_valid = 1'b0; predict_taken = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    #1;
    tests++; if (predict_history !== 32'h0) begin fails++; $display("FAIL reset_hist got %0h expected 0", predict_history); end
    tests++; if (occupancy !== 4'd0) begin fails++; $display("FAIL reset_occ got %0d expected 0", occupancy); end
    tests++; if (train_valid !== 1'b0 || err_underflow !== 1'b0) begin fails++; $display("FAIL reset_flags got tv=%b err=%b expected 0 0", train_valid, err_underflow); end
    tests++; if (predict_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b expected 1", predict_ready); end
    for (int i = 0; i < 3; i++) begin
      logic [2:0] et;
      et = i[2:0];
      predict_valid = 1'b1;
      predict_taken = tk_v[2-i];
      #1;
      tests++; if (predict_tag !== et || predict_ready !== 1'b1) begin fails++; $display("FAIL push_tag%0d got tag=%0d rdy=%b expected tag=%0d rdy=1", i, predict_tag, predict_ready, et); end
      tick();
    end
    predict_valid = 1'b0;
    tests++; if (predict_history !== 32'h5) begin fails++; $display("FAIL push3_hist got %0h expected 5", predict_history); end
    tests++; if (occupancy !== 4'd3) begin fails++; $display("FAIL push3_occ got %0d expected 3", occupancy); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) do_push(1'b1);
    tests++; if (occupancy !== 4'd8) begin fails++; $display("FAIL full_occ got %0d expected 8", occupancy); end
    tests++; if (predict_history !== 32'hBF) begin fails++; $display("FAIL full_hist got %0h expected bf", predict_history); end
    predict_valid = 1'b1; predict_taken = 1'b0;
    #1;
    tests++; if (predict_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b expected 0", predict_ready); end
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    #1;
    tests++; if (predict_ready !== 1'b0) begin fails++; $display("FAIL full_pop_ready got %b expected 0", predict_ready); end
    tick();
    predict_valid = 1'b0; resolve_valid = 1'b0;
    #1;
    tests++; if (occupancy !== 4'd7) begin fails++; $display("FAIL full_pop_occ got %0d expected 7", occupancy); end
    tests++; if (predict_history !== 32'hBF) begin fails++; $display("FAIL full_pop_hist got %0h expected bf", predict_history); end
    tests++; if (train_valid !== 1'b1 || train_mispredicted !== 1'b0 || train_taken !== 1'b1 || train_history !== 32'h0) begin
      fails++; $display("FAIL full_pop_train got v=%b m=%b t=%b h=%0h expected 1 0 1 0", train_valid, train_mispredicted, train_taken, train_history); end
    tests++; if (predict_ready !== 1'b1) begin fails++; $display("FAIL full_pop_ready_next got %b expected 1", predict_ready); end
  endtask

  task automatic test_mispredict();
    resetn = 1'b0; tick(); resetn = 1'b1;
    do_push(1'b1); do_push(1'b1); do_push(1'b0);
    tests++; if (predict_history !== 32'h6) begin fails++; $display("FAIL mp_pre_hist got %0h expected 6", predict_history); end
    resolve_valid = 1'b1; resolve_taken = 1'b0; predict_valid = 1'b1; predict_taken = 1'b1;
    #1;
    tests++; if (predict_ready !== 1'b0) begin fails++; $display("FAIL mp_ready_now got %b expected 0", predict_ready); end
    tick();
    resolve_valid = 1'b0; predict_valid = 1'b0;
    #1;
    tests++; if (train_valid !== 1'b1 || train_mispredicted !== 1'b1 || train_taken !== 1'b0 || train_history !== 32'h0) begin
      fails++; $display("FAIL mp_train got v=%b m=%b t=%b h=%0h expected 1 1 0 0", train_valid, train_mispredicted, train_taken, train_history); end
    tests++; if (predict_history !== 32'h0 || occupancy !== 4'd0) begin fails++; $display("FAIL mp_restore got hist=%0h occ=%0d expected 0 0", predict_history, occupancy); end
    tests++; if (predict_ready !== 1'b0) begin fails++; $display("FAIL mp_recover_ready got %b expected 0", predict_ready); end
    tick();
    tests++; if (predict_ready !== 1'b1) begin fails++; $display("FAIL mp_run_ready got %b expected 1", predict_ready); end
    tests++; if (train_valid !== 1'b0) begin fails++; $display("FAIL mp_train_pulse got %b expected 0", train_valid); end
  endtask

  task automatic test_back_to_back();
    do_push(1'b0); do_push(1'b1); do_push(1'b1); do_push(1'b0);
    tests++; if (occupancy !== 4'd4 || predict_history !== 32'h6) begin fails++; $display("FAIL b2b_pre got occ=%0d hist=%0h expected 4 6", occupancy, predict_history); end
    predict_valid = 1'b1; predict_taken = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b0;
    #1;
    tests++; if (predict_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b expected 1", predict_ready); end
    tick();
    predict_valid = 1'b0; resolve_valid = 1'b0;
    tests++; if (occupancy !== 4'd4 || predict_history !== 32'hD) begin fails++; $display("FAIL b2b_state got occ=%0d hist=%0h expected 4 d", occupancy, predict_history); end
    tests++; if (train_valid !== 1'b1 || train_mispredicted !== 1'b0 || train_history !== 32'h0) begin
      fails++; $display("FAIL b2b_train got v=%b m=%b h=%0h expected 1 0 0", train_valid, train_mispredicted, train_history); end
  endtask

  task automatic test_underflow();
    logic [3:0]        tk_v;
    logic [HIST_W-1:0] dh [4];
    tk_v = 4'b1011;
    dh[0] = 32'h0; dh[1] = 32'h1; dh[2] = 32'h3; dh[3] = 32'h6;
    for (int j = 0; j < 4; j++) begin
      resolve_valid = 1'b1; resolve_taken = tk_v[j];
      tick();
      resolve_valid = 1'b0;
      tests++; if (train_valid !== 1'b1 || train_mispredicted !== 1'b0 || train_history !== dh[j]) begin
        fails++; $display("FAIL drain%0d got v=%b m=%b h=%0h expected 1 0 %0h", j, train_valid, train_mispredicted, train_history, dh[j]); end
    end
    tests++; if (occupancy !== 4'd0) begin fails++; $display("FAIL drain_occ got %0d expected 0", occupancy); end
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    tick();
    resolve_valid = 1'b0;
    tests++; if (train_valid !== 1'b0) begin fails++; $display("FAIL uf_train got %b expected 0", train_valid); end
    tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_err got %b expected 1", err_underflow); end
    tests++; if (occupancy !== 4'd0 || predict_history !== 32'hD) begin fails++; $display("FAIL uf_state got occ=%0d hist=%0h expected 0 d", occupancy, predict_history); end
    do_push(1'b1);
    tick(); tick();
    tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky got %b expected 1", err_underflow); end
  endtask

  task automatic test_wrap_and_reset();
    logic [HIST_W-1:0] mh;
    logic [HIST_W-1:0] ph;
    logic              tk;
    resetn = 1'b0; tick(); resetn = 1'b1;
    tests++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL wrap_err_clr got %b expected 0", err_underflow); end
    mh = '0;
    for (int i = 0; i < 20; i++) begin
      logic [2:0] et;
      et = i[2:0];
      tk = ((i % 3) != 1);
      predict_valid = 1'b1; predict_taken = tk;
      #1;
      tests++; if (predict_tag !== et) begin fails++; $display("FAIL wrap_tag%0d got %0d expected %0d", i, predict_tag, et); end
      ph = mh;
      tick();
      predict_valid = 1'b0;
      mh = {mh[HIST_W-2:0], tk};
      resolve_valid = 1'b1; resolve_taken = tk;
      tick();
      resolve_valid = 1'b0;
      tests++; if (train_valid !== 1'b1 || train_mispredicted !== 1'b0 || train_history !== ph) begin
        fails++; $display("FAIL wrap_train%0d got v=%b m=%b h=%0h expected 1 0 %0h", i, train_valid, train_mispredicted, train_history, ph); end
      tests++; if (predict_history !== mh) begin fails++; $display("FAIL wrap_hist%0d got %0h expected %0h", i, predict_history, mh); end
    end
    for (int i = 0; i < 5; i++) do_push(1'b1);
    tests++; if (occupancy !== 4'd5) begin fails++; $display("FAIL pre_rst_occ got %0d expected 5", occupancy); end
    resetn = 1'b0;
    tick();
    tests++; if (predict_history !== 32'h0 || occupancy !== 4'd0 || predict_tag !== 3'd0) begin
      fails++; $display("FAIL mid_rst_state got hist=%0h occ=%0d tag=%0d expected 0 0 0", predict_history, occupancy, predict_tag); end
    tests++; if (train_valid !== 1'b0 || train_taken !== 1'b0 || train_mispredicted !== 1'b0 || train_history !== 32'h0 || err_underflow !== 1'b0) begin
      fails++; $display("FAIL mid_rst_train got v=%b t=%b m=%b h=%0h err=%b expected all 0", train_valid, train_taken, train_mispredicted, train_history, err_underflow); end
    tests++; if (predict_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready got %b expected 1", predict_ready); end
    resetn = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_full();
    test_mispredict();
    test_back_to_back();
    test_underflow();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
